// File: rtl/prio_pkg.sv
// Shared types and helpers for the registered priority arbiter.
// MAX_N bounds the request width that rotate_mask can describe.
package prio_pkg;

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } prio_mode_t;

    localparam int unsigned MAX_N = 32;

    // Keep every position at or below the one-hot pointer bit.
    // A zero pointer yields an all-ones mask.
    function automatic logic [MAX_N-1:0] rotate_mask(input logic [MAX_N-1:0] ptr_onehot);
        return ptr_onehot | (ptr_onehot - {{(MAX_N-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// N-to-W combinational priority encoder; the highest set bit wins.
// valid flags a non-zero request vector.
module prio_enc_n #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan upward so that the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx   = {W{1'b0}};
        valid = |req;
        for (int i = 0; i < int'(N); i++) begin
            idx = req[i] ? W'(i) : idx;
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered priority arbiter with fixed (MSB-first) and round-robin modes,
// presenting one grant at a time on a valid/ready output.
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         gnt_valid,
    input  logic         gnt_ready,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         any
);

    logic         gnt_valid_q,  gnt_valid_d;
    logic [W-1:0] gnt_idx_q,    gnt_idx_d;
    logic [N-1:0] gnt_onehot_q, gnt_onehot_d;
    logic [N-1:0] ptr_q,        ptr_d;

    prio_mode_t   mode_s;
    logic         accept_s;
    logic         slot_open_s;
    logic [N-1:0] rr_mask_s;
    logic [N-1:0] req_masked_s;
    logic [W-1:0] masked_idx_s;
    logic         masked_valid_s;
    logic [W-1:0] full_idx_s;
    logic         full_valid_s;
    logic [W-1:0] winner_s;

    assign mode_s = prio_mode_t'(mode);
    assign any    = |req;

    prio_enc_n #(.N(N)) u_enc_masked (
        .req   (req_masked_s),
        .idx   (masked_idx_s),
        .valid (masked_valid_s)
    );

    prio_enc_n #(.N(N)) u_enc_full (
        .req   (req),
        .idx   (full_idx_s),
        .valid (full_valid_s)
    );

    // Handshake decode and pointer advance; the mask uses the advanced
    // pointer so the just-served requester is already lowest priority.
    always_comb begin
        accept_s    = gnt_valid_q & gnt_ready;
        slot_open_s = ~gnt_valid_q | gnt_ready;
        ptr_d       = ptr_q;
        if (accept_s && (mode_s == PRIO_RR)) begin
            ptr_d = {gnt_onehot_q[0], gnt_onehot_q[N-1:1]};
        end else begin
            ptr_d = ptr_q;
        end
        rr_mask_s    = N'(rotate_mask(MAX_N'(ptr_d)));
        req_masked_s = req & rr_mask_s;
    end

    // Winner selection for the active mode.
    always_comb begin
        winner_s = full_idx_s;
        case (mode_s)
            PRIO_RR: begin
                if (masked_valid_s) begin
                    winner_s = masked_idx_s;
                end else begin
                    winner_s = full_idx_s;
                end
            end
            PRIO_FIXED: winner_s = full_idx_s;
            default:    winner_s = full_idx_s;
        endcase
    end

    // Output slot: reload when open, otherwise hold the pending grant.
    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        if (slot_open_s) begin
            if (full_valid_s) begin
                gnt_valid_d  = 1'b1;
                gnt_idx_d    = winner_s;
                gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << winner_s;
            end else begin
                gnt_valid_d  = 1'b0;
                gnt_idx_d    = gnt_idx_q;
                gnt_onehot_d = {N{1'b0}};
            end
        end else begin
            gnt_valid_d  = gnt_valid_q;
            gnt_idx_d    = gnt_idx_q;
            gnt_onehot_d = gnt_onehot_q;
        end
    end

    // State registers; the pointer restarts at N-1 to match fixed priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= {W{1'b0}};
            gnt_onehot_q <= {N{1'b0}};
            ptr_q        <= {1'b1, {(N-1){1'b0}}};
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            ptr_q        <= ptr_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8): reset, fixed sweep, backpressure,
// round-robin fairness and wrap, and reset during a pending grant.
module tb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic       gnt_valid;
    logic       gnt_ready;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       any;

    int tests = 0;
    int fails = 0;

    prio_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .any        (any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] exp_idx);
        logic [7:0] oh;
        oh = 8'h01 << exp_idx;
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
        check({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
        check({tag, "_onehot"}, 32'(gnt_onehot), 32'(oh));
    endtask

    logic [7:0] sweep_req [8];
    logic [2:0] rr_exp    [10];
    logic [2:0] wrap_exp  [5];

    initial begin
        sweep_req = '{8'h01, 8'h03, 8'h05, 8'h08, 8'h18, 8'h20, 8'h60, 8'hC0};
        rr_exp    = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
        wrap_exp  = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd0};

        // Reset with all requests high.
        rst = 1'b1; req = 8'hFF; mode = 1'b0; gnt_ready = 1'b1;
        #1;
        check("any_in_reset", 32'(any), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", 32'(gnt_valid), 32'd0);
            check("rst_idx", 32'(gnt_idx), 32'd0);
            check("rst_onehot", 32'(gnt_onehot), 32'd0);
        end
        rst = 1'b0;
        tick();
        check_grant("first_fixed", 3'd7);

        // Fixed-priority sweep, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            req = sweep_req[i];
            tick();
            check_grant("fixed_sweep", 3'(i));
        end
        req = 8'h00;
        #1;
        check("any_zero", 32'(any), 32'd0);
        tick();
        check("idle_valid", 32'(gnt_valid), 32'd0);
        check("idle_onehot", 32'(gnt_onehot), 32'd0);

        // Backpressure: grant held through request drop and higher priority.
        req = 8'h04; gnt_ready = 1'b0;
        tick();
        check_grant("hold_load", 3'd2);
        req = 8'h00;
        tick();
        check_grant("hold_drop", 3'd2);
        req = 8'h84;
        tick();
        check_grant("hold_higher", 3'd2);
        gnt_ready = 1'b1;
        tick();
        check_grant("after_hold", 3'd7);

        // Drain in fixed mode so the pointer stays at 7.
        req = 8'h00;
        tick();
        check("drain_valid", 32'(gnt_valid), 32'd0);

        // Round-robin fairness with everyone requesting.
        mode = 1'b1; req = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_grant("rr_fair", rr_exp[i]);
        end

        // Sparse requests wrap between 7 and 0.
        req = 8'h81;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant("rr_wrap", wrap_exp[i]);
        end
        req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("rr_single", 3'd0);
        end

        // Serve 7, 6, 5 then 4 is pending when reset hits.
        req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("rr_pre_rst", 3'(7 - i));
        end
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(gnt_valid), 32'd0);
        check("mid_rst_onehot", 32'(gnt_onehot), 32'd0);
        rst = 1'b0;
        tick();
        check_grant("post_rst", 3'd7);
        tick();
        check_grant("post_rst_next", 3'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

- Registered, parametrised priority arbiter: selects one of `N` request lines, encodes the winner as index plus one-hot, and presents it on a valid/ready output.
- Two priority modes:
  - fixed: MSB wins, same ordering as the team's combinational priority encoders;
  - round-robin: rotating priority, so no requester starves.
- Sits between request sources (interrupt lines, bus masters) and a consumer that accepts one grant per handshake.

## Interface
- `N`, 8: number of request lines, ≥2.
- `W`, `$clog2(N)`: width of the grant index; derived, not overridden.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: request vector, level-sensitive; bit i = requester i.
- `mode` input 1: 0 = fixed priority (bit N-1 highest), 1 = round-robin.
- `gnt_valid` output 1: a grant is held in the output register.
- `gnt_ready` input 1: consumer accepts the grant this cycle when `gnt_valid` is also high.
- `gnt_idx` output W: index of the granted requester.
- `gnt_onehot` output N: one-hot form of `gnt_idx`, all zeros when `gnt_valid`=0.
- `any` output 1: combinational OR of `req`; same meaning as the encoder "f" flag.

## Operation
- Output slot is "open" when `gnt_valid`=0, or when `gnt_valid`=1 and `gnt_ready`=1.
- When the slot is open, evaluate `req` on that edge:
  - non-zero: load the winner into `gnt_idx`/`gnt_onehot` and set `gnt_valid`=1;
  - zero: clear `gnt_valid`.
- When the slot is not open, the grant is held stable:
  - holds even if the winner drops its request (grant is not revoked);
  - holds even if a higher-priority request arrives.
- Fixed mode: winner is the highest set bit of `req`.
- Round-robin mode:
  - 1-of-N pointer `ptr` holds the highest-priority position.
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1 (descending with wrap).
  - On each accepted handshake, `ptr` becomes `(gnt_idx-1) mod N`: just-served index drops to lowest priority.
  - `ptr` changes only on accept, never on load, and not in fixed mode.
- A `mode` change takes effect at the next evaluation. `ptr` is not reset by a mode change.
- Reset values:
  - `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0;
  - `ptr`=N-1, so round-robin starts identical to fixed priority.
  - `any` follows `req` at all times, including during reset.
- Reset during a pending grant discards the grant. `gnt_ready` is ignored during reset.

## Timing
- Latency: `req` sampled at edge k gives `gnt_valid`/`gnt_idx` at edge k, visible in cycle k+1.
- Throughput: one grant per cycle when `gnt_ready` is held high.
- Accept and reload happen on the same edge: back-to-back grants have no bubble.
- The `ptr` update and the new-winner evaluation use the same edge:
  - the new winner is computed with the updated pointer (`gnt_idx-1`), not the old one;
  - so with `gnt_ready`=1 continuously, the same requester is never granted twice in a row while others request.
- `any` is combinational from `req`, with zero latency.
- Fixed mode never changes `ptr`, so fixed ↔ RR switching has no side effects on fixed behaviour.

## Structure
- Package `prio_pkg`:
  - `typedef enum logic {PRIO_FIXED, PRIO_RR} prio_mode_t`;
  - `function automatic rotate_mask(...)` building the round-robin masking vector from `ptr`.
- Sub-module `prio_enc_n`: parametrised `N`-to-`W` combinational priority encoder (MSB highest) with valid flag.
- Round-robin uses two instances of `prio_enc_n`:
  - instance 1 on `req & mask`, where mask keeps bits ≤ ptr;
  - instance 2 on unmasked `req`;
  - pick the masked result if it is valid, else the unmasked one.
- Fixed mode uses the unmasked instance only.
- Top level `prio_arbiter` holds the output register, `ptr`, and the handshake logic.

## Test plan
- Reset and fixed priority: assert `rst` 2 cycles with `req`=8'hFF, then release with `mode`=0, `gnt_ready`=1.
  - During reset: `gnt_valid`=0.
  - First grant after release: `gnt_idx`=7, `gnt_onehot`=8'h80.
- Fixed sweep: apply the same vectors as the combinational encoder bench, 8'h01, 8'h03, 8'h05, 8'h08, 8'h18, 8'h20, 8'h60, 8'hC0, one per cycle.
  - Expected `gnt_idx` one cycle later: 0, 1, 2, 3, 4, 5, 6, 7.
  - For `req`=8'h00: `gnt_valid`=0 and `any`=0.
- Hold under backpressure: `req`=8'h04, `gnt_ready`=0 for 3 cycles, then `req`=8'h84.
  - `gnt_idx` stays 2, `gnt_valid` stays 1.
  - After `gnt_ready`=1 for one cycle, next grant is 7.
- Round-robin fairness: `mode`=1, `req`=8'hFF, `gnt_ready`=1 for 10 cycles.
  - Grants are 7, 6, 5, 4, 3, 2, 1, 0, 7, 6.
- Round-robin wrap with sparse requests: `mode`=1, `req`=8'h81.
  - Grants alternate 7, 0, 7, 0.
  - Then `req`=8'h01 only: grants 0 every cycle.
- Reset mid-operation: in RR mode after grant 5 is accepted, assert `rst` 1 cycle with `gnt_valid` pending, `req`=8'hFF.
  - `gnt_valid` goes 0.
  - After release, first grant is 7 (`ptr` back to N-1).
